// File: rtl/exec_stage_if.sv
// Execute-stage bus: E-register inputs, downstream status/bubble controls,
// forwarding outputs, the M register, condition codes and the op counter.
// The slave modport belongs to exec_stage; the master modport belongs to
// whatever drives the E register and consumes the M register.
interface exec_stage_if;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [63:0] E_valC;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;

  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic        M_bubble;

  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE;

  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;

  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic [31:0] op_count;

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_Cnd, e_dstE,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    output cc_zf, cc_sf, cc_of, op_count
  );

  modport master (
    output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_Cnd, e_dstE,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  cc_zf, cc_sf, cc_of, op_count
  );
endinterface

// File: rtl/exec_stage.sv
// Y86-64 style execute stage: operand selection, 64-bit ALU, condition-code
// register, branch/cmov condition evaluation and the E->M pipeline register.
// Optional feature macro EXEC_OPCOUNT_EN: when defined, op_count counts the
// edges on which the condition codes are written; when undefined, op_count
// is tied to zero and no counter flops exist.
module exec_stage (
  input logic         clk,
  input logic         rst,
  exec_stage_if.slave bus
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_out;
  alu_fun_t    alu_fun;
  logic        new_zf;
  logic        new_sf;
  logic        new_of;
  logic        set_cc;
  logic        cnd;
  logic [3:0]  dst_e;
  logic        zf_q;
  logic        sf_q;
  logic        of_q;

  // Pick the ALU operands from the instruction class; stack ops use +/-8.
  always_comb begin
    alu_a = 64'd0;
    case (bus.E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
      I_CALL, I_PUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               alu_a = 64'd8;
      default:                     alu_a = 64'd0;
    endcase
    alu_b = 64'd0;
    case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_valB;
      default:                                                   alu_b = 64'd0;
    endcase
  end

  // Only OPq chooses its own ALU function; undefined function codes fall back to add.
  always_comb begin
    alu_fun = ALU_ADD;
    if (bus.E_icode == I_OPQ) begin
      case (bus.E_ifun)
        4'd1:    alu_fun = ALU_SUB;
        4'd2:    alu_fun = ALU_AND;
        4'd3:    alu_fun = ALU_XOR;
        default: alu_fun = ALU_ADD;
      endcase
    end
  end

  // ALU datapath plus the candidate flags derived from its result.
  always_comb begin
    alu_out = 64'd0;
    new_of  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        alu_out = alu_b + alu_a;
        new_of  = (alu_a[63] == alu_b[63]) && (alu_out[63] != alu_b[63]);
      end
      ALU_SUB: begin
        alu_out = alu_b - alu_a;
        new_of  = (alu_a[63] != alu_b[63]) && (alu_out[63] != alu_b[63]);
      end
      ALU_AND: alu_out = alu_b & alu_a;
      ALU_XOR: alu_out = alu_b ^ alu_a;
      default: alu_out = alu_b + alu_a;
    endcase
    new_zf = (alu_out == 64'd0);
    new_sf = alu_out[63];
  end

  // Flags are written only by an OPq whose downstream instructions have not faulted.
  assign set_cc = (bus.E_icode == I_OPQ) && (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);

  // Branch / conditional-move condition, evaluated against the committed flags.
  always_comb begin
    cnd = 1'b0;
    case (bus.E_ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf_q ^ of_q) | zf_q;
      4'd2:    cnd = sf_q ^ of_q;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = ~zf_q;
      4'd5:    cnd = ~(sf_q ^ of_q);
      4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

  // A conditional move that fails its condition must not write a register.
  assign dst_e = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;

  assign bus.e_valE = alu_out;
  assign bus.e_Cnd  = cnd;
  assign bus.e_dstE = dst_e;
  assign bus.cc_zf  = zf_q;
  assign bus.cc_sf  = sf_q;
  assign bus.cc_of  = of_q;

  // Condition-code register; a bubble in M does not block the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (set_cc) begin
      zf_q <= new_zf;
      sf_q <= new_sf;
      of_q <= new_of;
    end
  end

  // E->M pipeline register; reset and bubble both load a NOP with no destinations.
  always_ff @(posedge clk) begin
    if (rst || bus.M_bubble) begin
      bus.M_stat  <= S_AOK;
      bus.M_icode <= I_NOP;
      bus.M_Cnd   <= 1'b0;
      bus.M_valE  <= 64'd0;
      bus.M_valA  <= 64'd0;
      bus.M_dstE  <= RNONE;
      bus.M_dstM  <= RNONE;
    end else begin
      bus.M_stat  <= bus.E_stat;
      bus.M_icode <= bus.E_icode;
      bus.M_Cnd   <= cnd;
      bus.M_valE  <= alu_out;
      bus.M_valA  <= bus.E_valA;
      bus.M_dstE  <= dst_e;
      bus.M_dstM  <= bus.E_dstM;
    end
  end

`ifdef EXEC_OPCOUNT_EN
  logic [31:0] op_count_q;

  // Count flag-writing operations; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 32'd0;
    end else if (set_cc) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign bus.op_count = op_count_q;
`else
  assign bus.op_count = 32'd0;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: stimulus pushes expected post-edge state
// from a behavioural model; an independent monitor pops and compares after
// every rising edge. Forwarding outputs are checked before each edge.
module tb_exec_stage;

  typedef struct {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        zf;
    logic        sf;
    logic        of;
    logic [31:0] count;
  } exp_t;

  logic clk;
  logic rst;
  exec_stage_if bus ();

  exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        scoreboard[$];
  int          checks;
  int          failures;
  bit          model_valid;
  bit          mdl_zf;
  bit          mdl_sf;
  bit          mdl_of;
  logic [31:0] mdl_count;

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the instruction's meaning, with
  // overflow judged from the exact 65-bit signed result.
  task automatic applyStimulus(input bit r, input bit bub, input logic [1:0] st,
                               input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] va, input logic [63:0] vb,
                               input logic [63:0] vc, input logic [3:0] de,
                               input logic [3:0] dm, input logic [1:0] ms,
                               input logic [1:0] ws);
    logic [63:0]        a;
    logic [63:0]        b;
    logic [63:0]        res;
    logic signed [64:0] wide;
    int                 op;
    bit                 of;
    bit                 c;
    bit                 lt;
    bit                 setcc;
    logic [3:0]         dst;
    exp_t               e;

    @(negedge clk);
    rst          = r;
    bus.M_bubble = bub;
    bus.E_stat   = st;
    bus.E_icode  = ic;
    bus.E_ifun   = fn;
    bus.E_valA   = va;
    bus.E_valB   = vb;
    bus.E_valC   = vc;
    bus.E_dstE   = de;
    bus.E_dstM   = dm;
    bus.m_stat   = ms;
    bus.W_stat   = ws;
    #1;

    if (ic == 4'h2 || ic == 4'h6)                    a = va;
    else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) a = vc;
    else if (ic == 4'h8 || ic == 4'hA)               a = -64'd8;
    else if (ic == 4'h9 || ic == 4'hB)               a = 64'd8;
    else                                             a = 64'd0;
    b  = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? vb : 64'd0;
    op = (ic == 4'h6 && fn < 4) ? int'(fn) : 0;

    of = 1'b0;
    if (op == 0) begin
      res  = b + a;
      wide = $signed({b[63], b}) + $signed({a[63], a});
      of   = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    end else if (op == 1) begin
      res  = b - a;
      wide = $signed({b[63], b}) - $signed({a[63], a});
      of   = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    end else if (op == 2) begin
      res = b & a;
    end else begin
      res = b ^ a;
    end

    lt = mdl_sf ^ mdl_of;
    case (fn)
      4'd0:    c = 1'b1;
      4'd1:    c = lt || mdl_zf;
      4'd2:    c = lt;
      4'd3:    c = mdl_zf;
      4'd4:    c = !mdl_zf;
      4'd5:    c = !lt;
      4'd6:    c = !lt && !mdl_zf;
      default: c = 1'b0;
    endcase
    dst   = (ic == 4'h2 && !c) ? 4'hF : de;
    setcc = (ic == 4'h6) && (ms == 2'd0) && (ws == 2'd0);

    if (model_valid) begin
      checkOutput("e_valE", bus.e_valE, res);
      checkOutput("e_Cnd", {63'd0, bus.e_Cnd}, {63'd0, c});
      checkOutput("e_dstE", {60'd0, bus.e_dstE}, {60'd0, dst});
    end

    if (r || bub) begin
      e.stat = 2'd0; e.icode = 4'h1; e.cnd = 1'b0; e.val_e = 64'd0;
      e.val_a = 64'd0; e.dst_e = 4'hF; e.dst_m = 4'hF;
    end else begin
      e.stat = st; e.icode = ic; e.cnd = c; e.val_e = res;
      e.val_a = va; e.dst_e = dst; e.dst_m = dm;
    end

    if (r) begin
      mdl_zf = 1'b1; mdl_sf = 1'b0; mdl_of = 1'b0; mdl_count = 32'd0;
      model_valid = 1'b1;
    end else if (setcc) begin
      mdl_zf = (res == 64'd0); mdl_sf = res[63]; mdl_of = of;
      mdl_count = mdl_count + 32'd1;
    end
    e.zf = mdl_zf; e.sf = mdl_sf; e.of = mdl_of;
`ifdef EXEC_OPCOUNT_EN
    e.count = mdl_count;
`else
    e.count = 32'd0;
`endif
    scoreboard.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the registered state with the oldest expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput("M_stat", {62'd0, bus.M_stat}, {62'd0, e.stat});
      checkOutput("M_icode", {60'd0, bus.M_icode}, {60'd0, e.icode});
      checkOutput("M_Cnd", {63'd0, bus.M_Cnd}, {63'd0, e.cnd});
      checkOutput("M_valE", bus.M_valE, e.val_e);
      checkOutput("M_valA", bus.M_valA, e.val_a);
      checkOutput("M_dstE", {60'd0, bus.M_dstE}, {60'd0, e.dst_e});
      checkOutput("M_dstM", {60'd0, bus.M_dstM}, {60'd0, e.dst_m});
      checkOutput("cc_flags", {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of}, {61'd0, e.zf, e.sf, e.of});
      checkOutput("op_count", {32'd0, bus.op_count}, {32'd0, e.count});
    end
  end

  function automatic logic [63:0] pick_value();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      4:       v = 64'(unsigned'($urandom_range(0, 16)));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    checks      = 0;
    failures    = 0;
    model_valid = 1'b0;
    mdl_zf      = 1'b1;
    mdl_sf      = 1'b0;
    mdl_of      = 1'b0;
    mdl_count   = 32'd0;
    rst         = 1'b1;
    bus.M_bubble = 1'b0;
    bus.E_stat  = 2'd0; bus.E_icode = 4'h1; bus.E_ifun = 4'h0;
    bus.E_valA  = 64'd0; bus.E_valB = 64'd0; bus.E_valC = 64'd0;
    bus.E_dstE  = 4'hF; bus.E_dstM = 4'hF; bus.m_stat = 2'd0; bus.W_stat = 2'd0;

    applyStimulus(1, 0, 0, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0);
    applyStimulus(1, 0, 0, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0);
    // Signed overflow on subtract: 0x8000.. - 0x7FFF.. = 1 with OF set.
    applyStimulus(0, 0, 0, 4'h6, 4'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 4'h2, 4'hF, 0, 0);
    // Equal operands set ZF, then je in the following cycle sees it.
    applyStimulus(0, 0, 0, 4'h6, 4'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h2, 4'hF, 0, 0);
    applyStimulus(0, 0, 0, 4'h7, 4'h3, 0, 0, 64'h40, 4'hF, 4'hF, 0, 0);
    // Downstream fault blocks the flag write and the count.
    applyStimulus(0, 0, 0, 4'h6, 4'h0, 64'd5, 64'd3, 0, 4'h1, 4'hF, 2'd2, 0);
    // cmovl with SF=OF=0 is suppressed.
    applyStimulus(0, 0, 0, 4'h2, 4'h2, 64'h1234, 0, 0, 4'h3, 4'hF, 0, 0);
    applyStimulus(0, 0, 0, 4'hA, 4'h0, 64'h55, 64'h100, 0, 4'h4, 4'hF, 0, 0);
    applyStimulus(0, 0, 0, 4'hB, 4'h0, 64'h0, 64'hF8, 0, 4'h4, 4'h7, 0, 0);
    // Bubble in M while an OPq still writes flags.
    applyStimulus(0, 1, 3, 4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h5, 4'h6, 0, 0);
    applyStimulus(0, 0, 0, 4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 0, 0);
    // Reset wins over bubble and a pending flag write.
    applyStimulus(1, 1, 0, 4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h5, 4'hF, 0, 0);
    applyStimulus(0, 0, 1, 4'h5, 4'h0, 64'h9, 64'h1000, 64'h20, 4'hF, 4'h8, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      logic [3:0] fn;
      ic = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ic = 4'h6;
      fn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
                    2'($urandom_range(0, 3)), ic, fn, pick_value(), pick_value(), pick_value(),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd0,
                    ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd0);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drain", 64'(scoreboard.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
- REQ-001 SHALL have one clock and one reset: `clk  in  1` is the rising-edge clock; `rst  in  1` is a synchronous, active-high reset.
- REQ-002 SHALL have the execute-register inputs:
  - `E_stat  in  2`: 0 AOK, 1 HLT, 2 ADR, 3 INS.
  - `E_icode  in  4`, `E_ifun  in  4`.
  - `E_valA  in  64`, `E_valB  in  64`, `E_valC  in  64`.
  - `E_dstE  in  4`, `E_dstM  in  4`: register IDs; 0xF means RNONE.
- REQ-003 SHALL have the control inputs:
  - `m_stat  in  2`, `W_stat  in  2`: status of the downstream stages.
  - `M_bubble  in  1`: inject a bubble into the M register.
- REQ-004 SHALL have the combinational outputs `e_valE  out  64`, `e_Cnd  out  1` and `e_dstE  out  4`, used for forwarding.
- REQ-005 SHALL have the registered outputs `M_stat  out  2`, `M_icode  out  4`, `M_Cnd  out  1`, `M_valE  out  64`, `M_valA  out  64`, `M_dstE  out  4` and `M_dstM  out  4`.
- REQ-006 SHALL have the condition-code outputs `cc_zf`, `cc_sf`, `cc_of` (`out  1` each) and the counter output `op_count  out  32`.

Function
- REQ-007 SHALL select aluA as follows:
  - valA for RRMOVQ(2) and OPQ(6).
  - valC for IRMOVQ(3), RMMOVQ(4) and MRMOVQ(5).
  - -8 for CALL(8) and PUSHQ(A).
  - +8 for RET(9) and POPQ(B).
  - 0 otherwise.
- REQ-008 SHALL select aluB as valB for icodes 4, 5, 6, 8, 9, A and B, and 0 otherwise.
- REQ-009 SHALL use alufun = E_ifun when icode=OPQ, and ADD otherwise.
- REQ-010 SHALL compute the ALU result as 0 ADD aluB+aluA, 1 SUB aluB-aluA, 2 AND, 3 XOR; all arithmetic is modulo 2^64 and unused ifun codes yield ADD.
- REQ-011 SHALL compute the new flags from e_valE:
  - ZF = (e_valE==0).
  - SF = e_valE[63].
  - OF for ADD = sign(aluA)==sign(aluB) and sign(result)!=sign(aluB).
  - OF for SUB = sign(aluA)!=sign(aluB) and sign(result)!=sign(aluB).
  - OF = 0 for AND and XOR.
- REQ-012 SHALL define set_cc = (E_icode==OPQ) and (m_stat==AOK) and (W_stat==AOK), and load the CC register with the new flags on the clk edge only when set_cc=1.
- REQ-013 SHALL compute e_Cnd combinationally from the current CC register, not from the new flags. The encodings by ifun are:
  - 0 always.
  - 1 LE = (SF^OF)|ZF.
  - 2 L = SF^OF.
  - 3 E = ZF.
  - 4 NE = !ZF.
  - 5 GE = !(SF^OF).
  - 6 G = !(SF^OF)&!ZF.
  - any other value yields 0.
- REQ-014 SHALL drive e_dstE = 0xF when E_icode==RRMOVQ and e_Cnd==0, and E_dstE otherwise.
- REQ-015 SHALL, on each clk edge with rst=0 and M_bubble=0, load the M register as follows:
  - M_stat ← E_stat, M_icode ← E_icode, M_Cnd ← e_Cnd.
  - M_valE ← e_valE, M_valA ← E_valA.
  - M_dstE ← e_dstE, M_dstM ← E_dstM.
- REQ-016 SHALL give e_valE to M_valE a latency of exactly one cycle, and a CC update SHALL be visible to the instruction in E on the following cycle.
- REQ-017 SHALL, on a clk edge with M_bubble=1, load the bubble value: M_stat=AOK, M_icode=NOP(1), M_Cnd=0, M_valE=M_valA=0, M_dstE=M_dstM=0xF.
- REQ-018 SHALL still compute e_* and update CC per set_cc while M_bubble=1, because bubbling M does not suppress the current E-stage CC write.

Reset
- REQ-019 SHALL, on a clk edge with rst=1:
  - load the M register with the bubble value of REQ-017;
  - set CC to ZF=1, SF=0, OF=0;
  - clear op_count to 0.
- REQ-020 SHALL give rst priority over M_bubble and set_cc when they are asserted simultaneously.
- REQ-021 SHALL leave no partial state after reset mid-operation: the first edge after rst deasserts behaves per REQ-015.

Configuration
- REQ-022 SHALL behave per macro EXEC_OPCOUNT_EN:
  - Defined: op_count increments by 1 (wrapping 0xFFFFFFFF→0) on each edge where set_cc=1 and rst=0.
  - Undefined: op_count is constant 0 and no counter flops are inferred.

Verification
- REQ-023 SHALL pass: OPQ SUB, valA=0x7FFFFFFFFFFFFFFF, valB=0x8000000000000000, m/W_stat AOK -> e_valE=0x1; after the edge M_valE=0x1 and ZF=0, SF=0, OF=1.
- REQ-024 SHALL pass: OPQ SUB with valA=valB=0x7FFFFFFFFFFFFFFF -> CC ZF=1, SF=0, OF=0; next cycle jXX ifun=3 -> e_Cnd=1, and M_Cnd=1 after the edge.
- REQ-025 SHALL pass: OPQ ADD 5+3 with m_stat=ADR -> M_valE=8; CC unchanged from its prior value; op_count unchanged.
- REQ-026 SHALL pass: with CC SF=0, OF=0, issue CMOVL (icode 2, ifun 2) with E_dstE=3 -> e_Cnd=0, e_dstE=0xF, M_dstE=0xF.
- REQ-027 SHALL pass: PUSHQ valB=0x100 -> M_valE=0xF8; POPQ valB=0xF8 -> M_valE=0x100; M_bubble=1 on the next edge -> M_icode=1, M_dstE=M_dstM=0xF, M_stat=0.
- REQ-028 SHALL pass: rst=1 for one edge after an OPQ set SF=1 -> CC returns to ZF=1, SF=0, OF=0; the M register holds the bubble value; with EXEC_OPCOUNT_EN defined, op_count=0.
